// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end sharing one ALU
//
// alu          : combinational ALU, opcodes 0000-1001, zero result otherwise.
// alu_arbiter  : IDLE -> EXEC -> RESP sequencer around one shared alu.
//   clk_in, rst_n_in                    clock, asynchronous active-low reset
//   reqk_valid_in / reqk_ready_out      request handshake, k in {0,1}
//   reqk_op_in, reqk_s_in, reqk_t_in,   opcode, operands, shift amount
//   reqk_shamt_in
//   resp_valid_out / resp_ready_in      response handshake
//   resp_id_out, resp_result_out,       requester index, result, illegal-op flag
//   resp_err_out
//   busy_out                            high whenever state is not IDLE
// Optional feature macro: ALU_ARB_OPCHK_EN (flag opcodes 1010-1111 on resp_err_out).

module alu #(
  parameter int BUS_WIDTH = 32
) (
  input  logic [3:0]           op,
  input  logic [BUS_WIDTH-1:0] s,
  input  logic [BUS_WIDTH-1:0] t,
  input  logic [4:0]           shamt,
  output logic [BUS_WIDTH-1:0] result
);
  always_comb begin
    result = '0;
    case (op)
      4'b0000: result = s & t;
      4'b0001: result = s | t;
      4'b0010: result = s + t;
      4'b0011: result = s ^ t;
      4'b0100: result = t << s[4:0];
      4'b0101: result = t >> s[4:0];
      4'b0110: result = s - t;
      4'b0111: result = '0 - s;
      4'b1000: result = t << shamt;
      4'b1001: result = t >> shamt;
      default: result = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 req0_valid_in,
  output logic                 req0_ready_out,
  input  logic [3:0]           req0_op_in,
  input  logic [BUS_WIDTH-1:0] req0_s_in,
  input  logic [BUS_WIDTH-1:0] req0_t_in,
  input  logic [4:0]           req0_shamt_in,
  input  logic                 req1_valid_in,
  output logic                 req1_ready_out,
  input  logic [3:0]           req1_op_in,
  input  logic [BUS_WIDTH-1:0] req1_s_in,
  input  logic [BUS_WIDTH-1:0] req1_t_in,
  input  logic [4:0]           req1_shamt_in,
  output logic                 resp_valid_out,
  input  logic                 resp_ready_in,
  output logic                 resp_id_out,
  output logic [BUS_WIDTH-1:0] resp_result_out,
  output logic                 resp_err_out,
  output logic                 busy_out
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t               state;
  logic                 last_grant;
  logic [3:0]           op_q;
  logic [BUS_WIDTH-1:0] s_q;
  logic [BUS_WIDTH-1:0] t_q;
  logic [4:0]           shamt_q;
  logic                 id_q;
  logic [BUS_WIDTH-1:0] alu_result;
  logic                 pick1;
  logic                 accept;

  // Requester 1 wins when it is alone, or on a tie when requester 0 was granted last.
  assign pick1  = req1_valid_in & (~req0_valid_in | ~last_grant);
  assign accept = (state == IDLE) & (req0_valid_in | req1_valid_in);

  assign req0_ready_out = accept & ~pick1;
  assign req1_ready_out = accept & pick1;
  assign busy_out       = (state != IDLE);

  alu #(.BUS_WIDTH(BUS_WIDTH)) u_alu (
    .op     (op_q),
    .s      (s_q),
    .t      (t_q),
    .shamt  (shamt_q),
    .result (alu_result)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      last_grant      <= 1'b1;  // so requester 0 wins the first tie
      op_q            <= '0;
      s_q             <= '0;
      t_q             <= '0;
      shamt_q         <= '0;
      id_q            <= 1'b0;
      resp_valid_out  <= 1'b0;
      resp_id_out     <= 1'b0;
      resp_result_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q       <= pick1 ? req1_op_in    : req0_op_in;
            s_q        <= pick1 ? req1_s_in     : req0_s_in;
            t_q        <= pick1 ? req1_t_in     : req0_t_in;
            shamt_q    <= pick1 ? req1_shamt_in : req0_shamt_in;
            id_q       <= pick1;
            last_grant <= pick1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          resp_result_out <= alu_result;
          resp_id_out     <= id_q;
          resp_valid_out  <= 1'b1;
          state           <= RESP;
        end
        RESP: begin
          if (resp_ready_in) begin
            resp_valid_out <= 1'b0;
            state          <= IDLE;
          end
        end
        default: begin
          resp_valid_out <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_OPCHK_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      resp_err_out <= 1'b0;
    end else if (state == EXEC) begin
      resp_err_out <= (op_q > 4'd9);
    end
  end
`else
  assign resp_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter

module tb_alu_arbiter;
  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        req0_valid_in, req0_ready_out;
  logic [3:0]  req0_op_in;
  logic [31:0] req0_s_in, req0_t_in;
  logic [4:0]  req0_shamt_in;
  logic        req1_valid_in, req1_ready_out;
  logic [3:0]  req1_op_in;
  logic [31:0] req1_s_in, req1_t_in;
  logic [4:0]  req1_shamt_in;
  logic        resp_valid_out, resp_ready_in, resp_id_out, resp_err_out, busy_out;
  logic [31:0] resp_result_out;

  int errors = 0;
  int checks = 0;
  logic exp_id;
  logic exp_illegal_err;

  alu_arbiter #(.BUS_WIDTH(32)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .req0_valid_in   (req0_valid_in),
    .req0_ready_out  (req0_ready_out),
    .req0_op_in      (req0_op_in),
    .req0_s_in       (req0_s_in),
    .req0_t_in       (req0_t_in),
    .req0_shamt_in   (req0_shamt_in),
    .req1_valid_in   (req1_valid_in),
    .req1_ready_out  (req1_ready_out),
    .req1_op_in      (req1_op_in),
    .req1_s_in       (req1_s_in),
    .req1_t_in       (req1_t_in),
    .req1_shamt_in   (req1_shamt_in),
    .resp_valid_out  (resp_valid_out),
    .resp_ready_in   (resp_ready_in),
    .resp_id_out     (resp_id_out),
    .resp_result_out (resp_result_out),
    .resp_err_out    (resp_err_out),
    .busy_out        (busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset;
    rst_n_in      = 1'b0;
    req0_valid_in = 1'b0;
    req1_valid_in = 1'b0;
    resp_ready_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  // One full operation from requester k with resp_ready held high.
  task automatic run_op(input string tag, input int k, input logic [3:0] op,
                        input logic [31:0] s, input logic [31:0] t, input logic [4:0] sh,
                        input logic [31:0] exp_r, input logic exp_e);
    resp_ready_in = 1'b1;
    if (k == 0) begin
      req0_op_in = op; req0_s_in = s; req0_t_in = t; req0_shamt_in = sh;
      req0_valid_in = 1'b1; req1_valid_in = 1'b0;
    end else begin
      req1_op_in = op; req1_s_in = s; req1_t_in = t; req1_shamt_in = sh;
      req1_valid_in = 1'b1; req0_valid_in = 1'b0;
    end
    #1;
    check({tag, "_ready"}, (k == 0) ? req0_ready_out : req1_ready_out, 32'd1);
    tick;
    req0_valid_in = 1'b0;
    req1_valid_in = 1'b0;
    check({tag, "_exec_valid"}, resp_valid_out, 32'd0);
    tick;
    check({tag, "_valid"}, resp_valid_out, 32'd1);
    check({tag, "_id"}, resp_id_out, k[31:0]);
    check({tag, "_result"}, resp_result_out, exp_r);
    check({tag, "_err"}, resp_err_out, exp_e);
    tick;
    check({tag, "_done_valid"}, resp_valid_out, 32'd0);
    check({tag, "_done_busy"}, busy_out, 32'd0);
  endtask

  initial begin
`ifdef ALU_ARB_OPCHK_EN
    exp_illegal_err = 1'b1;
`else
    exp_illegal_err = 1'b0;
`endif
    req0_op_in = '0; req0_s_in = '0; req0_t_in = '0; req0_shamt_in = '0;
    req1_op_in = '0; req1_s_in = '0; req1_t_in = '0; req1_shamt_in = '0;

    // Reset state
    rst_n_in = 1'b0; req0_valid_in = 1'b0; req1_valid_in = 1'b0; resp_ready_in = 1'b0;
    #3;
    check("rst_valid", resp_valid_out, 32'd0);
    check("rst_busy", busy_out, 32'd0);
    check("rst_id", resp_id_out, 32'd0);
    check("rst_result", resp_result_out, 32'd0);
    check("rst_err", resp_err_out, 32'd0);
    check("rst_ready0", req0_ready_out, 32'd0);
    check("rst_ready1", req1_ready_out, 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Idle with no request: no ready, stay idle
    tick;
    check("idle_ready0", req0_ready_out, 32'd0);
    check("idle_busy", busy_out, 32'd0);

    // Add 5+3, with ready low while busy even if valid stays up
    req0_op_in = 4'b0010; req0_s_in = 32'd5; req0_t_in = 32'd3; req0_valid_in = 1'b1;
    resp_ready_in = 1'b0;
    #1;
    check("add_ready0", req0_ready_out, 32'd1);
    check("add_ready1", req1_ready_out, 32'd0);
    tick;
    check("add_exec_busy", busy_out, 32'd1);
    check("add_exec_ready0", req0_ready_out, 32'd0);
    check("add_exec_valid", resp_valid_out, 32'd0);
    tick;
    check("add_valid", resp_valid_out, 32'd1);
    check("add_result", resp_result_out, 32'd8);
    check("add_id", resp_id_out, 32'd0);
    check("add_err", resp_err_out, 32'd0);
    check("add_resp_ready0", req0_ready_out, 32'd0);
    req0_valid_in = 1'b0;
    resp_ready_in = 1'b1;
    tick;
    check("add_done_valid", resp_valid_out, 32'd0);

    // Round-robin with both valid after a fresh reset: 0,1,0,1
    do_reset;
    req0_op_in = 4'b0000; req0_s_in = 32'h0000F0F0; req0_t_in = 32'h0000FF00;
    req1_op_in = 4'b0001; req1_s_in = 32'h0000000F; req1_t_in = 32'h000000F0;
    req0_valid_in = 1'b1; req1_valid_in = 1'b1; resp_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2) == 1;
      #1;
      check("rr_ready0", req0_ready_out, {31'd0, ~exp_id});
      check("rr_ready1", req1_ready_out, {31'd0, exp_id});
      tick;
      check("rr_busy", busy_out, 32'd1);
      tick;
      check("rr_valid", resp_valid_out, 32'd1);
      check("rr_id", resp_id_out, {31'd0, exp_id});
      check("rr_result", resp_result_out, exp_id ? 32'h000000FF : 32'h0000F000);
      tick;
    end
    req0_valid_in = 1'b0; req1_valid_in = 1'b0;

    // Response held under backpressure for 5 cycles
    req1_op_in = 4'b1000; req1_t_in = 32'h1; req1_shamt_in = 5'd31; req1_valid_in = 1'b1;
    resp_ready_in = 1'b0;
    #1;
    check("hold_ready1", req1_ready_out, 32'd1);
    tick;
    tick;
    req0_valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", resp_valid_out, 32'd1);
      check("hold_result", resp_result_out, 32'h80000000);
      check("hold_id", resp_id_out, 32'd1);
      check("hold_busy", busy_out, 32'd1);
      check("hold_ready0", req0_ready_out, 32'd0);
      check("hold_ready1", req1_ready_out, 32'd0);
      tick;
    end
    req0_valid_in = 1'b0; req1_valid_in = 1'b0;
    resp_ready_in = 1'b1;
    tick;
    check("hold_release_valid", resp_valid_out, 32'd0);

    // Opcode coverage
    run_op("sub", 0, 4'b0110, 32'd0, 32'd1, 5'd0, 32'hFFFFFFFF, 1'b0);
    run_op("neg", 0, 4'b0111, 32'd1, 32'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
    run_op("addwrap", 1, 4'b0010, 32'hFFFFFFFF, 32'd2, 5'd0, 32'd1, 1'b0);
    run_op("xor", 0, 4'b0011, 32'hA5A5A5A5, 32'hFFFF0000, 5'd0, 32'h5A5AA5A5, 1'b0);
    run_op("sllv", 1, 4'b0100, 32'd4, 32'd1, 5'd0, 32'd16, 1'b0);
    run_op("srlv", 0, 4'b0101, 32'd3, 32'h80, 5'd0, 32'h10, 1'b0);
    run_op("srl", 1, 4'b1001, 32'd0, 32'h80000000, 5'd31, 32'd1, 1'b0);
    run_op("illegal", 0, 4'b1100, 32'h1234, 32'h5678, 5'd3, 32'd0, exp_illegal_err);
    run_op("illegal_max", 1, 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'd0, exp_illegal_err);

    // Reset during EXEC discards the operation
    req0_op_in = 4'b0010; req0_s_in = 32'd1; req0_t_in = 32'd1; req0_valid_in = 1'b1;
    resp_ready_in = 1'b1;
    #1;
    tick;
    req0_valid_in = 1'b0;
    check("mid_exec_busy", busy_out, 32'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("mid_rst_valid", resp_valid_out, 32'd0);
    check("mid_rst_busy", busy_out, 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tick;
    check("post_rst_valid_a", resp_valid_out, 32'd0);
    tick;
    check("post_rst_valid_b", resp_valid_out, 32'd0);
    run_op("post_rst_add", 0, 4'b0010, 32'd7, 32'd8, 5'd0, 32'd15, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
